// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the scoreboard: FSM states, winner codes, default sizes.
package scoreboard_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HOLD      = 2'd1,
      GAME_OVER = 2'd2
   } state_e;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_A    = 2'b01;
   localparam logic [1:0] WIN_B    = 2'b10;

   localparam int SCORE_W_DEF   = 5;
   localparam int WIN_SCORE_DEF = 11;

endpackage

// File: rtl/score_controller_if.sv
// Event/score bundle between the pushbutton processors, the score controller and the display.
interface score_controller_if #(
   parameter int SCORE_W = 5
);
   logic               a_up_i;
   logic               a_down_i;
   logic               b_up_i;
   logic               b_down_i;
   logic               new_game_i;
   logic [SCORE_W-1:0] score_a_o;
   logic [SCORE_W-1:0] score_b_o;
   logic [1:0]         winner_o;
   logic               game_over_o;
   logic               update_o;
   logic               overflow_o;

   modport master (
      output a_up_i, a_down_i, b_up_i, b_down_i, new_game_i,
      input  score_a_o, score_b_o, winner_o, game_over_o, update_o, overflow_o
   );

   modport slave (
      input  a_up_i, a_down_i, b_up_i, b_down_i, new_game_i,
      output score_a_o, score_b_o, winner_o, game_over_o, update_o, overflow_o
   );
endinterface

// File: rtl/score_pending.sv
// Per-player pending up/down flags with set-over-clear priority and dropped-event detection.
module score_pending (
   input  logic clk,
   input  logic rst_n,
   input  logic up_i,
   input  logic down_i,
   input  logic clr_i,
   input  logic discard_i,
   input  logic flush_i,
   output logic up_o,
   output logic dn_o,
   output logic drop_o
);

   logic up_q, up_d;
   logic dn_q, dn_d;

   // A pulse landing on the clearing edge re-arms the flag so the event survives.
   always_comb begin
      up_d   = up_q;
      dn_d   = dn_q;
      drop_o = 1'b0;
      if (flush_i) begin
         up_d = 1'b0;
         dn_d = 1'b0;
      end else begin
         if (clr_i) begin
            up_d = 1'b0;
            dn_d = 1'b0;
         end
         if (!discard_i) begin
            if (up_i) begin
               up_d = 1'b1;
               if (up_q && !clr_i) drop_o = 1'b1;
            end
            if (down_i) begin
               dn_d = 1'b1;
               if (dn_q && !clr_i) drop_o = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_q <= 1'b0;
         dn_q <= 1'b0;
      end else begin
         up_q <= up_d;
         dn_q <= dn_d;
      end
   end

   assign up_o = up_q;
   assign dn_o = dn_q;

endmodule

// File: rtl/score_controller.sv
// Round-robin score sequencer with saturating scores and win detection.
// Define SCORE_WIN_BY_TWO_EN to require a 2-point lead in addition to WIN_SCORE.
module score_controller
   import scoreboard_pkg::*;
#(
   parameter int SCORE_W   = SCORE_W_DEF,
   parameter int WIN_SCORE = WIN_SCORE_DEF
) (
   input logic              clk_1mhz,
   input logic              rst_n,
   score_controller_if.slave bus
);

   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
   localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

   state_e             state_q, state_d;
   logic [SCORE_W-1:0] score_a_q, score_a_d;
   logic [SCORE_W-1:0] score_b_q, score_b_d;
   logic [1:0]         winner_q, winner_d;
   logic               overflow_q, overflow_d;
   logic               rr_q, rr_d;
   logic               last_q, last_d;

   logic a_up, a_dn, a_drop, clr_a;
   logic b_up, b_dn, b_drop, clr_b;
   logic discard, lead_a, lead_b, grant_b;

   assign discard = (state_q == GAME_OVER) || bus.new_game_i;

   score_pending u_pend_a (
      .clk(clk_1mhz), .rst_n(rst_n), .up_i(bus.a_up_i), .down_i(bus.a_down_i),
      .clr_i(clr_a), .discard_i(discard), .flush_i(bus.new_game_i),
      .up_o(a_up), .dn_o(a_dn), .drop_o(a_drop)
   );

   score_pending u_pend_b (
      .clk(clk_1mhz), .rst_n(rst_n), .up_i(bus.b_up_i), .down_i(bus.b_down_i),
      .clr_i(clr_b), .discard_i(discard), .flush_i(bus.new_game_i),
      .up_o(b_up), .dn_o(b_dn), .drop_o(b_drop)
   );

`ifdef SCORE_WIN_BY_TWO_EN
   assign lead_a = ({1'b0, score_a_q} >= ({1'b0, score_b_q} + (SCORE_W+1)'(2)));
   assign lead_b = ({1'b0, score_b_q} >= ({1'b0, score_a_q} + (SCORE_W+1)'(2)));
`else
   assign lead_a = 1'b1;
   assign lead_b = 1'b1;
`endif

   function automatic logic [SCORE_W-1:0] next_score(input logic [SCORE_W-1:0] s,
                                                     input logic up, input logic dn);
      logic [SCORE_W-1:0] r;
      r = s;
      if (up && !dn && (s != SCORE_MAX)) r = s + 1'b1;
      if (dn && !up && (s != '0))        r = s - 1'b1;
      return r;
   endfunction

   // rr_q/last_q: 0 means player A. new_game_i overrides everything at the end.
   always_comb begin
      state_d    = state_q;
      score_a_d  = score_a_q;
      score_b_d  = score_b_q;
      winner_d   = winner_q;
      overflow_d = overflow_q | a_drop | b_drop;
      rr_d       = rr_q;
      last_d     = last_q;
      clr_a      = 1'b0;
      clr_b      = 1'b0;
      grant_b    = (b_up || b_dn) && (!(a_up || a_dn) || rr_q);
      unique case (state_q)
         IDLE: begin
            if (grant_b) begin
               score_b_d = next_score(score_b_q, b_up, b_dn);
               clr_b     = 1'b1;
               rr_d      = 1'b0;
               last_d    = 1'b1;
               state_d   = HOLD;
            end else if (a_up || a_dn) begin
               score_a_d = next_score(score_a_q, a_up, a_dn);
               clr_a     = 1'b1;
               rr_d      = 1'b1;
               last_d    = 1'b0;
               state_d   = HOLD;
            end
         end
         HOLD: begin
            if (!last_q && (score_a_q >= WIN_VAL) && lead_a) begin
               winner_d = WIN_A;
               state_d  = GAME_OVER;
            end else if (last_q && (score_b_q >= WIN_VAL) && lead_b) begin
               winner_d = WIN_B;
               state_d  = GAME_OVER;
            end else begin
               state_d  = IDLE;
            end
         end
         GAME_OVER: state_d = GAME_OVER;
         default:   state_d = IDLE;
      endcase
      if (bus.new_game_i) begin
         state_d    = IDLE;
         score_a_d  = '0;
         score_b_d  = '0;
         winner_d   = WIN_NONE;
         overflow_d = 1'b0;
         rr_d       = 1'b0;
         last_d     = 1'b0;
      end
   end

   always_ff @(posedge clk_1mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         score_a_q  <= '0;
         score_b_q  <= '0;
         winner_q   <= WIN_NONE;
         overflow_q <= 1'b0;
         rr_q       <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         score_a_q  <= score_a_d;
         score_b_q  <= score_b_d;
         winner_q   <= winner_d;
         overflow_q <= overflow_d;
         rr_q       <= rr_d;
         last_q     <= last_d;
      end
   end

   assign bus.score_a_o   = score_a_q;
   assign bus.score_b_o   = score_b_q;
   assign bus.winner_o    = winner_q;
   assign bus.game_over_o = (state_q == GAME_OVER);
   assign bus.update_o    = (state_q == HOLD);
   assign bus.overflow_o  = overflow_q;

endmodule

// File: tb/tb_score_controller.sv
// Directed self-checking bench for score_controller; honours SCORE_WIN_BY_TWO_EN for the win test.
`timescale 1ns/1ps
module tb_score_controller;

   logic clk_1mhz;
   logic rst_n;
   int   errors;
   int   checks;

   score_controller_if #(.SCORE_W(5)) bus ();

   score_controller #(.SCORE_W(5), .WIN_SCORE(11)) dut (
      .clk_1mhz(clk_1mhz),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk_1mhz = 1'b0;
   always #500 clk_1mhz = ~clk_1mhz;

   // Drives one set of pulses for exactly one clock, returning 1ns after the sampling edge.
   task automatic applyStimulus(input logic au, input logic ad, input logic bu,
                                input logic bd, input logic ng);
      bus.a_up_i     = au;
      bus.a_down_i   = ad;
      bus.b_up_i     = bu;
      bus.b_down_i   = bd;
      bus.new_game_i = ng;
      @(posedge clk_1mhz);
      #1;
      bus.a_up_i     = 1'b0;
      bus.a_down_i   = 1'b0;
      bus.b_up_i     = 1'b0;
      bus.b_down_i   = 1'b0;
      bus.new_game_i = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_1mhz);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      @(posedge clk_1mhz);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      errors         = 0;
      checks         = 0;
      rst_n          = 1'b0;
      bus.a_up_i     = 1'b0;
      bus.a_down_i   = 1'b0;
      bus.b_up_i     = 1'b0;
      bus.b_down_i   = 1'b0;
      bus.new_game_i = 1'b0;
      repeat (2) @(posedge clk_1mhz);
      #1;
      checkOutput("rst_score_a", 32'(bus.score_a_o), 0);
      checkOutput("rst_score_b", 32'(bus.score_b_o), 0);
      checkOutput("rst_winner", 32'(bus.winner_o), 0);
      checkOutput("rst_game_over", 32'(bus.game_over_o), 0);
      checkOutput("rst_update", 32'(bus.update_o), 0);
      checkOutput("rst_overflow", 32'(bus.overflow_o), 0);
      rst_n = 1'b1;

      // Single event: score lands one edge after the flag, update for one cycle.
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("single_pending", 32'(bus.score_a_o), 0);
      step(1);
      checkOutput("single_score_a", 32'(bus.score_a_o), 1);
      checkOutput("single_update_hi", 32'(bus.update_o), 1);
      step(1);
      checkOutput("single_update_lo", 32'(bus.update_o), 0);
      checkOutput("single_winner", 32'(bus.winner_o), 0);

      // Simultaneous A and B after reset: A first, B two cycles later.
      doReset();
      applyStimulus(1, 0, 1, 0, 0);
      step(1);
      checkOutput("simul_a_first", 32'(bus.score_a_o), 1);
      checkOutput("simul_b_wait", 32'(bus.score_b_o), 0);
      checkOutput("simul_upd1", 32'(bus.update_o), 1);
      step(1);
      checkOutput("simul_gap", 32'(bus.update_o), 0);
      step(1);
      checkOutput("simul_b_second", 32'(bus.score_b_o), 1);
      checkOutput("simul_upd2", 32'(bus.update_o), 1);

      // Floor at zero still strobes; up+down together is net zero.
      doReset();
      applyStimulus(0, 0, 0, 1, 0);
      step(1);
      checkOutput("floor_b", 32'(bus.score_b_o), 0);
      checkOutput("floor_update", 32'(bus.update_o), 1);
      step(1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 0, 0);
         step(2);
      end
      checkOutput("three_ups", 32'(bus.score_a_o), 3);
      applyStimulus(1, 1, 0, 0, 0);
      step(1);
      checkOutput("netzero_a", 32'(bus.score_a_o), 3);
      checkOutput("netzero_update", 32'(bus.update_o), 1);

      // Pulse on the clearing edge is kept, not dropped.
      doReset();
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("coincide_first", 32'(bus.score_a_o), 1);
      step(2);
      checkOutput("coincide_second", 32'(bus.score_a_o), 2);
      checkOutput("coincide_no_ovf", 32'(bus.overflow_o), 0);

      // Overflow: second A pulse while A waits behind a B grant.
      doReset();
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("overflow_set", 32'(bus.overflow_o), 1);
      step(1);
      checkOutput("overflow_score", 32'(bus.score_a_o), 1);
      checkOutput("overflow_hold", 32'(bus.update_o), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_score_a", 32'(bus.score_a_o), 0);
      checkOutput("midrst_score_b", 32'(bus.score_b_o), 0);
      checkOutput("midrst_update", 32'(bus.update_o), 0);
      checkOutput("midrst_overflow", 32'(bus.overflow_o), 0);
      @(posedge clk_1mhz);
      #1;
      rst_n = 1'b1;

`ifdef SCORE_WIN_BY_TWO_EN
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 0, 0, 0, 0);
         step(2);
         applyStimulus(0, 0, 1, 0, 0);
         step(2);
      end
      checkOutput("deuce_a", 32'(bus.score_a_o), 10);
      checkOutput("deuce_b", 32'(bus.score_b_o), 10);
      applyStimulus(1, 0, 0, 0, 0);
      step(2);
      checkOutput("by2_a11", 32'(bus.score_a_o), 11);
      checkOutput("by2_no_winner", 32'(bus.winner_o), 0);
      checkOutput("by2_playing", 32'(bus.game_over_o), 0);
      applyStimulus(1, 0, 0, 0, 0);
      step(2);
      checkOutput("by2_a12", 32'(bus.score_a_o), 12);
      checkOutput("by2_winner", 32'(bus.winner_o), 1);
      checkOutput("by2_game_over", 32'(bus.game_over_o), 1);
`else
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1, 0, 0, 0, 0);
         step(2);
      end
      checkOutput("win_score_a", 32'(bus.score_a_o), 11);
      checkOutput("win_winner", 32'(bus.winner_o), 1);
      checkOutput("win_game_over", 32'(bus.game_over_o), 1);
`endif

      // Frozen game: pulses are discarded without touching overflow.
      applyStimulus(0, 0, 1, 0, 0);
      step(2);
      checkOutput("frozen_b", 32'(bus.score_b_o), 0);
      checkOutput("frozen_go", 32'(bus.game_over_o), 1);
      checkOutput("frozen_ovf", 32'(bus.overflow_o), 0);

      // New game wins over a coincident pulse.
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("newgame_a", 32'(bus.score_a_o), 0);
      checkOutput("newgame_winner", 32'(bus.winner_o), 0);
      checkOutput("newgame_go", 32'(bus.game_over_o), 0);
      applyStimulus(1, 0, 0, 0, 1);
      step(2);
      checkOutput("newgame_discard_a", 32'(bus.score_a_o), 0);
      checkOutput("newgame_discard_upd", 32'(bus.update_o), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
